// File: rtl/pipe_hazard_sequencer.sv
// Y86-64 five-stage pipeline sequencing controller.
// Stall/bubble decode, run/drain/halt FSM and saturating perf counters.
module pipe_hazard_sequencer #(
  parameter int         CNT_W = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             restart,
  input  logic             e_cnd,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc_en,
  output logic             halted,
  output logic [2:0]       halt_code,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [2:0] S_AOK    = 3'd1;

  state_t st;

  logic lu;
  logic ret;
  logic mp;
  logic exc_m;
  logic exc_w;

  assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ))
            && (E_dstM != RNONE)
            && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret = (D_icode == I_RET) || (E_icode == I_RET)
            || (M_icode == I_RET);
  assign mp    = (E_icode == I_JXX) && !e_cnd;
  assign exc_m = (m_stat != S_AOK);
  assign exc_w = (W_stat != S_AOK);

  assign state  = st;
  assign halted = (st == HALT);

  // Per-stage control decode from the current state and hazards
  always_comb begin
    F_stall   = 1'b1;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b1;
    M_bubble  = 1'b1;
    W_stall   = 1'b0;
    set_cc_en = 1'b0;
    unique case (st)
      IDLE: begin
        D_bubble = 1'b1;
      end
      RUN: begin
        F_stall   = lu | ret;
        D_stall   = lu;
        D_bubble  = mp | (ret & ~lu);
        E_bubble  = mp | lu;
        M_bubble  = exc_m | exc_w;
        W_stall   = exc_w;
        set_cc_en = (E_icode == I_OPQ) & ~exc_m & ~exc_w;
      end
      DRAIN: begin
        D_stall = 1'b1;
      end
      HALT: begin
        D_stall = 1'b1;
        W_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Run/drain/halt sequencing and halt cause capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      halt_code <= 3'd0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) st <= RUN;
        end
        RUN: begin
          if (exc_w) begin
            st        <= HALT;
            halt_code <= W_stat;
          end else if (exc_m) begin
            st <= DRAIN;
          end
        end
        DRAIN: begin
          if (exc_w) begin
            st        <= HALT;
            halt_code <= W_stat;
          end else if (!exc_m) begin
            st <= RUN;
          end
        end
        HALT: begin
          if (restart) begin
            st        <= IDLE;
            halt_code <= 3'd0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  logic active;
  logic in_run;
  assign active = (st == RUN) || (st == DRAIN);
  assign in_run = (st == RUN);

  // Saturating counters; frozen outside RUN/DRAIN, cleared on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (st == HALT && restart) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (active && !(&cycle_cnt))
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (in_run && F_stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (in_run && E_bubble && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scoreboard bench for pipe_hazard_sequencer.
// Driver queues expectations; monitor pops and compares.
module tb_pipe_hazard_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n4;
  logic start;
  logic restart;
  logic e_cnd;
  logic [3:0] D_icode, E_icode, M_icode;
  logic [3:0] d_srcA, d_srcB, E_dstM;
  logic [2:0] m_stat, W_stat;

  logic F_stall, D_stall, D_bubble, E_bubble;
  logic M_bubble, W_stall, set_cc_en, halted;
  logic [2:0] halt_code;
  logic [1:0] state;
  logic [31:0] cycle_cnt, stall_cnt, bubble_cnt;

  logic F_stall4, D_stall4, D_bubble4, E_bubble4;
  logic M_bubble4, W_stall4, set_cc_en4, halted4;
  logic [2:0] halt_code4;
  logic [1:0] state4;
  logic [3:0] cycle_cnt4, stall_cnt4, bubble_cnt4;

  always #5 clk = ~clk;

  pipe_hazard_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .restart(restart), .e_cnd(e_cnd),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc_en(set_cc_en), .halted(halted),
    .halt_code(halt_code), .state(state),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  pipe_hazard_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n4),
    .start(start), .restart(restart), .e_cnd(e_cnd),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall4), .D_stall(D_stall4), .D_bubble(D_bubble4),
    .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
    .set_cc_en(set_cc_en4), .halted(halted4),
    .halt_code(halt_code4), .state(state4),
    .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4),
    .bubble_cnt(bubble_cnt4)
  );

  typedef enum int {
    S_CTRL, S_STATE, S_HCODE, S_CYC, S_STL, S_BUB,
    S_CTRL4, S_STATE4, S_CYC4, S_STL4, S_BUB4
  } sel_t;

  typedef struct {
    string name;
    sel_t  sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  event chk;
  int n_pass = 0;
  int n_total = 0;

  // ctrl vector: {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc_en,halted}
  function automatic logic [31:0] actual(sel_t s);
    case (s)
      S_CTRL:   return {24'd0, F_stall, D_stall, D_bubble, E_bubble,
                        M_bubble, W_stall, set_cc_en, halted};
      S_STATE:  return {30'd0, state};
      S_HCODE:  return {29'd0, halt_code};
      S_CYC:    return cycle_cnt;
      S_STL:    return stall_cnt;
      S_BUB:    return bubble_cnt;
      S_CTRL4:  return {24'd0, F_stall4, D_stall4, D_bubble4, E_bubble4,
                        M_bubble4, W_stall4, set_cc_en4, halted4};
      S_STATE4: return {30'd0, state4};
      S_CYC4:   return {28'd0, cycle_cnt4};
      S_STL4:   return {28'd0, stall_cnt4};
      S_BUB4:   return {28'd0, bubble_cnt4};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: drain the scoreboard each time outputs are presented
  initial begin
    forever begin
      @(chk);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = sb.pop_front();
        a = actual(e.sel);
        n_total++;
        if (a === e.val) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
      end
    end
  end

  task automatic expect_val(string name, sel_t sel, logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic present();
    #1;
    -> chk;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic defaults();
    start = 0; restart = 0; e_cnd = 0;
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  localparam logic [31:0] C_IDLE = 32'b1011_1000;
  localparam logic [31:0] C_LU   = 32'b1101_0000;
  localparam logic [31:0] C_RET  = 32'b1010_0000;
  localparam logic [31:0] C_MP   = 32'b0011_0000;
  localparam logic [31:0] C_EXC  = 32'b0000_1000;
  localparam logic [31:0] C_CC   = 32'b0000_0010;
  localparam logic [31:0] C_DRN  = 32'b1101_1000;
  localparam logic [31:0] C_HLT  = 32'b1101_1101;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    defaults();
    rst_n = 0;
    rst_n4 = 0;
    step();
    step();
    expect_val("rst_ctrl", S_CTRL, C_IDLE);
    expect_val("rst_state", S_STATE, 0);
    expect_val("rst_hcode", S_HCODE, 0);
    expect_val("rst_cyc", S_CYC, 0);
    present();

    rst_n = 1;
    step();
    expect_val("idle_hold", S_STATE, 0);
    present();

    start = 1;
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    step();
    start = 0;
    expect_val("start_run", S_STATE, 1);
    expect_val("lu_ctrl", S_CTRL, C_LU);
    present();
    step();
    expect_val("lu_stall_cnt", S_STL, 1);
    expect_val("lu_bub_cnt", S_BUB, 1);
    expect_val("lu_cyc_cnt", S_CYC, 1);
    present();

    defaults();
    D_icode = 4'h9;
    expect_val("ret_d", S_CTRL, C_RET);
    present();
    step();
    D_icode = 4'h1; E_icode = 4'h9;
    expect_val("ret_e", S_CTRL, C_RET);
    present();
    step();
    E_icode = 4'h1; M_icode = 4'h9;
    expect_val("ret_m", S_CTRL, C_RET);
    present();
    step();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    expect_val("ret_lu", S_CTRL, C_LU);
    present();
    step();
    expect_val("cnt_cyc5", S_CYC, 5);
    expect_val("cnt_stl5", S_STL, 5);
    expect_val("cnt_bub2", S_BUB, 2);
    present();

    defaults();
    E_icode = 4'h7;
    expect_val("mispred", S_CTRL, C_MP);
    present();
    step();
    e_cnd = 1;
    expect_val("taken_ok", S_CTRL, 0);
    present();
    step();

    defaults();
    E_icode = 4'h6; m_stat = 3'd4;
    expect_val("cc_blocked", S_CTRL, C_EXC);
    present();
    m_stat = 3'd1;
    expect_val("cc_enabled", S_CTRL, C_CC);
    present();
    step();
    expect_val("cnt_cyc8", S_CYC, 8);
    expect_val("cnt_stl_keep", S_STL, 5);
    expect_val("cnt_bub3", S_BUB, 3);
    present();

    defaults();
    m_stat = 3'd3;
    expect_val("exc_m_ctrl", S_CTRL, C_EXC);
    present();
    step();
    expect_val("to_drain", S_STATE, 2);
    expect_val("drain_ctrl", S_CTRL, C_DRN);
    present();
    m_stat = 3'd1; W_stat = 3'd3;
    step();
    W_stat = 3'd1; start = 1;
    expect_val("to_halt", S_STATE, 3);
    expect_val("halt_ctrl", S_CTRL, C_HLT);
    expect_val("halt_code3", S_HCODE, 3);
    expect_val("halt_cyc", S_CYC, 10);
    present();
    step();
    step();
    start = 0;
    expect_val("halt_sticky", S_STATE, 3);
    expect_val("halt_cyc_frz", S_CYC, 10);
    present();
    restart = 1;
    step();
    restart = 0;
    expect_val("restart_idle", S_STATE, 0);
    expect_val("restart_cyc", S_CYC, 0);
    expect_val("restart_stl", S_STL, 0);
    expect_val("restart_bub", S_BUB, 0);
    expect_val("restart_hc", S_HCODE, 0);
    present();

    start = 1;
    step();
    start = 0;
    m_stat = 3'd3;
    step();
    expect_val("squash_drain", S_STATE, 2);
    present();
    m_stat = 3'd1;
    step();
    expect_val("squash_run", S_STATE, 1);
    present();

    rst_n4 = 1;
    start = 1;
    step();
    start = 0;
    expect_val("sat_run", S_STATE4, 1);
    present();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    for (int i = 0; i < 20; i++) step();
    expect_val("sat_cyc", S_CYC4, 15);
    expect_val("sat_stl", S_STL4, 15);
    expect_val("sat_bub", S_BUB4, 15);
    present();
    defaults();
    m_stat = 3'd3;
    step();
    expect_val("sat_drain", S_STATE4, 2);
    expect_val("main_drain", S_STATE, 2);
    present();
    rst_n4 = 0;
    rst_n = 0;
    expect_val("arst4_state", S_STATE4, 0);
    expect_val("arst4_cyc", S_CYC4, 0);
    expect_val("arst4_ctrl", S_CTRL4, C_IDLE);
    expect_val("arst_state", S_STATE, 0);
    expect_val("arst_cyc", S_CYC, 0);
    present();

    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
